barret_mul_feed_2273: RTL and testbench
=======================================

Name: barret_mul_feed_2273

Overview:
Upstream feeder for the mod-2273 Barrett reducer.
- Accepts streamed operand pairs (a, b), each a residue in [0, 2272].
- Forms the full 23-bit product a*b (max 2272*2272 = 5161984 < 2^23), which is exactly the reducer's input width.
- Two-stage elastic pipeline with valid/ready on both sides; frame tracking and a running product counter.

Parameters:
Q, 2273, modulus; operand legality bound.
W_OP, 12, operand width.
W_PROD, 23, product width; must equal the reducer's input width.
W_CNT, 16, product counter width.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  stage can accept operand pair
in_a  in  W_OP  operand a
in_b  in  W_OP  operand b
in_last  in  1  marks last pair of a frame
out_valid  out  1  product valid
out_ready  in  1  downstream accepts product
out_prod  out  W_PROD  product a*b (to reducer din_a)
out_last  out  1  frame marker travelling with product
frame_done  out  1  one-cycle pulse on handshake of an out_last product
prod_count  out  W_CNT  products emitted since reset, wraps 2^W_CNT-1 -> 0
busy  out  1  any stage holds data
op_error  out  1  sticky illegal-operand flag (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): s1_valid=0, s2_valid=0, out_valid=0, out_prod=0, out_last=0, frame_done=0, prod_count=0, busy=0, op_error=0. in_ready=1 from the first cycle after release. Reset mid-stream discards all in-flight pairs; there is no replay.
- Stage 1: registers a, b, last on an input handshake (in_valid && in_ready).
- Stage 2: registers a*b (full W_PROD, unsigned, no truncation) and last.
- Advance rules:
  - s2_free = !s2_valid || out_ready.
  - s1 moves into s2 when s1_valid && s2_free.
  - in_ready = !s1_valid || (s1 moves). This is a combinational path from out_ready; accepted, documented.
- Latency: 2 cycles from input handshake to out_valid when unstalled. Throughput: 1 pair/cycle sustained with out_ready=1.
- Stall: while out_valid && !out_ready, out_prod and out_last are held stable. Capacity is 2 pairs; a third pair sees in_ready=0. No loss, duplication, or reordering.
- Simultaneous output handshake and s1 move in the same cycle: s2 reloads with no bubble.
- prod_count increments by 1 on each output handshake (out_valid && out_ready) and wraps silently.
- frame_done=1 on exactly the cycle of an output handshake with out_last=1, otherwise 0.
- busy = s1_valid || s2_valid.
- out_valid=0 implies out_prod is don't-care to the consumer; the RTL still holds the last value.

Optional Feature:
Macro OPERAND_CHECK_EN.
- Defined: at stage-1 capture, any pair with a >= Q or b >= Q has its product forced to 0 and sets op_error=1. op_error is sticky and cleared only by rst_n. The handshake and the count are unaffected.
- Undefined: no check, products are passed as computed, and op_error is tied 0. The port remains present.

Decomposition:
- Package barret_2273_pkg: Q, W_OP, W_PROD, W_CNT, MAX_PROD=5161984, and the operand and product typedefs. Shared with the reducer and the downstream stages.
- Sub-module barret_pipe_stage: one elastic valid/ready register slice, parameterised by payload width. Instantiated twice; the multiplier sits between the two instances.

Test Plan:
1. Reset: after 10 transfers, pull rst_n low mid-stall -> out_valid=0, prod_count=0, busy=0 immediately. in_ready=1 in the first cycle after release.
2. Corner: a=2272, b=2272 with out_ready=1 -> out_prod=5161984 two cycles after accept. a=0, b=1234 -> out_prod=0.
3. Stream: a=i, b=1 for i=0..2272 back-to-back with out_ready=1 -> out_prod=i on consecutive cycles and prod_count=2273 at the end. Chained through the reducer, every result equals (i*1) mod 2273.
4. Backpressure: random in_valid/out_ready toggling over 1000 random legal pairs -> scoreboard matches a*b in order. in_ready=0 while 2 entries are held. out_prod stable during every stall.
5. Frame: in_last on the 4th pair -> out_last and frame_done high only on the 4th output handshake. frame_done stays low if that handshake is stalled.
6. OPERAND_CHECK_EN defined: a=2273, b=5 -> out_prod=0, op_error=1, and op_error persists until rst_n. Undefined: same stimulus -> out_prod=11365, op_error=0.

Source files
------------

// File: rtl/barret_mul_feed_2273_pkg.sv
// Shared constants and types for the mod-2273 Barrett datapath (feeder, reducer, downstream).
// Operand and product widths here must stay in step with the reducer's input width.
package barret_2273_pkg;

    localparam int Q        = 2273;
    localparam int W_OP     = 12;
    localparam int W_PROD   = 23;
    localparam int W_CNT    = 16;
    localparam int MAX_PROD = 5161984;

    typedef logic [W_OP-1:0]   operand_t;
    typedef logic [W_PROD-1:0] prod_t;
    typedef logic [W_CNT-1:0]  cnt_t;

    typedef struct packed {
        logic     bad;
        logic     last;
        operand_t a;
        operand_t b;
    } s1_word_t;

    typedef struct packed {
        logic  last;
        prod_t prod;
    } s2_word_t;

    function automatic logic operand_illegal(input operand_t a, input operand_t b);
        return (a >= operand_t'(Q)) || (b >= operand_t'(Q));
    endfunction

    // Widen before multiplying so the full 23-bit product is kept.
    function automatic prod_t full_product(input operand_t a, input operand_t b);
        return prod_t'(a) * prod_t'(b);
    endfunction

endpackage

// File: rtl/barret_mul_feed_2273_if.sv
// Operand-in / product-out streaming bus of the Barrett feeder.
// master = producer of operands and consumer of products; slave = the feeder itself.
interface barret_mul_feed_2273_if;
    import barret_2273_pkg::*;

    logic     in_valid;
    logic     in_ready;
    operand_t in_a;
    operand_t in_b;
    logic     in_last;
    logic     out_valid;
    logic     out_ready;
    prod_t    out_prod;
    logic     out_last;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_prod, out_last
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_prod, out_last
    );

endinterface

// File: rtl/barret_mul_feed_2273_pipe_stage.sv
// One elastic valid/ready register slice with a full-throughput ready path.
// in_ready depends combinationally on out_ready so a full slice can reload in the pop cycle.
module barret_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;
    logic         free;

    always_comb begin
        free    = !valid_q || out_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (free) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = free;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/barret_mul_feed_2273.sv
// Operand feeder for the mod-2273 Barrett reducer: two elastic slices with the full multiply between them.
// Optional operand range check is built in when OPERAND_CHECK_EN is defined.
module barret_mul_feed_2273
    import barret_2273_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    barret_mul_feed_2273_if.slave  bus,
    output logic                   frame_done,
    output cnt_t                   prod_count,
    output logic                   busy,
    output logic                   op_error
);

    s1_word_t s1_in, s1_out;
    s2_word_t s2_in, s2_out;
    logic     s1_valid, s2_valid, s2_ready;
    logic     in_bad, in_hs, out_hs;

    cnt_t     prod_count_q, prod_count_d;
    logic     op_error_q,   op_error_d;

`ifdef OPERAND_CHECK_EN
    assign in_bad = operand_illegal(bus.in_a, bus.in_b);
`else
    assign in_bad = 1'b0;
`endif

    assign s1_in = '{bad: in_bad, last: bus.in_last, a: bus.in_a, b: bus.in_b};

    barret_pipe_stage #(.W($bits(s1_word_t))) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_out)
    );

    // Illegal pairs still flow through so handshake and count are undisturbed.
    always_comb begin
        s2_in.last = s1_out.last;
        s2_in.prod = s1_out.bad ? '0 : full_product(s1_out.a, s1_out.b);
    end

    barret_pipe_stage #(.W($bits(s2_word_t))) u_stage2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (s2_valid),
        .out_ready (bus.out_ready),
        .out_data  (s2_out)
    );

    assign bus.out_valid = s2_valid;
    assign bus.out_prod  = s2_out.prod;
    assign bus.out_last  = s2_out.last;

    assign in_hs  = bus.in_valid && bus.in_ready;
    assign out_hs = s2_valid && bus.out_ready;

    always_comb begin
        prod_count_d = prod_count_q + cnt_t'(out_hs);
        op_error_d   = op_error_q || (in_hs && in_bad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_count_q <= '0;
            op_error_q   <= 1'b0;
        end else begin
            prod_count_q <= prod_count_d;
            op_error_q   <= op_error_d;
        end
    end

    assign frame_done = out_hs && s2_out.last;
    assign prod_count = prod_count_q;
    assign busy       = s1_valid || s2_valid;
    assign op_error   = op_error_q;

endmodule

// File: tb/tb_barret_mul_feed_2273.sv
// Directed bench for barret_mul_feed_2273: reset, corners, stream, backpressure, frames, operand check.
// Outputs are sampled 1 time unit after inputs settle (away from the rising edge).
module tb_barret_mul_feed_2273;
    import barret_2273_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    barret_mul_feed_2273_if bus ();
    logic frame_done, busy, op_error;
    cnt_t prod_count;

    barret_mul_feed_2273 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .frame_done (frame_done),
        .prod_count (prod_count),
        .busy       (busy),
        .op_error   (op_error)
    );

    int        errors = 0;
    int        checks = 0;
    s2_word_t  sb[$];
    int        occ = 0;
    cnt_t      cnt_model = '0;
    bit        stall_prev = 1'b0;
    prod_t     held_prod = '0;
    bit        last_in_hs = 1'b0;
    int        fd_pulses = 0;
    prod_t     last_pop_prod = '0;
    int        pushed;
    logic [31:0] exp_err;

    function automatic prod_t exp_prod(input operand_t a, input operand_t b);
`ifdef OPERAND_CHECK_EN
        if (a >= 12'd2273 || b >= 12'd2273) return '0;
`endif
        return prod_t'(a) * prod_t'(b);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        occ        = 0;
        cnt_model  = '0;
        stall_prev = 1'b0;
    endtask

    task automatic step(input bit iv, input operand_t a, input operand_t b,
                        input bit il, input bit ordy);
        bit       in_hs, out_hs, exp_fd;
        s2_word_t w;
        bus.in_valid  = iv;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_last   = il;
        bus.out_ready = ordy;
        #1;
        in_hs  = iv && bus.in_ready;
        out_hs = bus.out_valid && ordy;
        if (occ == 2 && !ordy) chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        if (stall_prev) begin
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_prod", 32'(bus.out_prod), 32'(held_prod));
        end
        exp_fd = 1'b0;
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'(bus.out_valid), 32'd0);
            end else begin
                chk("prod", 32'(bus.out_prod), 32'(sb[0].prod));
                chk("last", 32'(bus.out_last), 32'(sb[0].last));
                exp_fd = ordy && sb[0].last;
            end
        end
        chk("frame_done", 32'(frame_done), 32'(exp_fd));
        if (frame_done) fd_pulses++;
        if (out_hs) begin
            cnt_model++;
            last_pop_prod = bus.out_prod;
            if (sb.size() > 0) begin
                void'(sb.pop_front());
                occ--;
            end
        end
        if (in_hs) begin
            w.last = il;
            w.prod = exp_prod(a, b);
            sb.push_back(w);
            occ++;
        end
        stall_prev = bus.out_valid && !ordy;
        held_prod  = bus.out_prod;
        last_in_hs = in_hs;
        @(posedge clk);
        #1;
        chk("prod_count", 32'(prod_count), 32'(cnt_model));
        chk("busy", 32'(busy), 32'(occ != 0));
        @(negedge clk);
    endtask

    task automatic send(input operand_t a, input operand_t b, input bit il, input bit ordy);
        for (int k = 0; k < 50; k++) begin
            step(1'b1, a, b, il, ordy);
            if (last_in_hs) return;
        end
        chk("send_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (occ == 0 && !bus.out_valid) return;
            step(1'b0, '0, '0, 1'b0, 1'b1);
        end
        chk("drain_timeout", 32'(occ), 32'd0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_prod_count", 32'(prod_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_error", 32'(op_error), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
`ifdef OPERAND_CHECK_EN
        exp_err = 32'd1;
`else
        exp_err = 32'd0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("init_out_valid", 32'(bus.out_valid), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_count", 32'(prod_count), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("init_in_ready", 32'(bus.in_ready), 32'd1);

        // 10 transfers, then fill both slices under stall and reset mid-stall
        for (int i = 0; i < 10; i++) send(operand_t'(i + 1), 12'd3, 1'b0, 1'b1);
        drain();
        chk("count_10", 32'(prod_count), 32'd10);
        step(1'b1, 12'd7, 12'd8, 1'b0, 1'b0);
        step(1'b1, 12'd9, 12'd10, 1'b0, 1'b0);
        step(1'b1, 12'd11, 12'd12, 1'b0, 1'b0);
        chk("stalled_full", 32'(occ), 32'd2);
        do_reset();

        // corners and latency
        send(12'd2272, 12'd2272, 1'b0, 1'b1);
        chk("lat1_valid", 32'(bus.out_valid), 32'd0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("lat2_valid", 32'(bus.out_valid), 32'd1);
        chk("corner_max", 32'(bus.out_prod), 32'd5161984);
        send(12'd0, 12'd1234, 1'b0, 1'b1);
        drain();
        chk("corner_zero", 32'(last_pop_prod), 32'd0);

        // full residue stream
        do_reset();
        for (int i = 0; i <= 2272; i++) send(operand_t'(i), 12'd1, 1'b0, 1'b1);
        drain();
        chk("stream_count", 32'(prod_count), 32'd2273);

        // random backpressure
        pushed = 0;
        for (int cyc = 0; cyc < 20000 && (pushed < 1000 || occ > 0); cyc++) begin
            step((pushed < 1000) && ($urandom_range(0, 9) < 7),
                 operand_t'($urandom_range(0, 2272)), operand_t'($urandom_range(0, 2272)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 6));
            if (last_in_hs) pushed++;
        end
        chk("bp_pushed", 32'(pushed), 32'd1000);
        chk("bp_drained", 32'(occ), 32'd0);

        // frame marker with a stalled last handshake
        do_reset();
        fd_pulses = 0;
        send(12'd1, 12'd2, 1'b0, 1'b1);
        send(12'd3, 12'd4, 1'b0, 1'b1);
        send(12'd5, 12'd6, 1'b0, 1'b1);
        send(12'd7, 12'd8, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("frame_last_shown", 32'(bus.out_last), 32'd1);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("frame_no_pulse_stalled", 32'(fd_pulses), 32'd0);
        drain();
        chk("frame_pulses", 32'(fd_pulses), 32'd1);
        chk("frame_last_prod", 32'(last_pop_prod), 32'd56);

        // operand range check
        do_reset();
        send(12'd2273, 12'd5, 1'b0, 1'b1);
        drain();
`ifdef OPERAND_CHECK_EN
        chk("op_prod", 32'(last_pop_prod), 32'd0);
`else
        chk("op_prod", 32'(last_pop_prod), 32'd11365);
`endif
        chk("op_error_set", 32'(op_error), exp_err);
        send(12'd3, 12'd4, 1'b0, 1'b1);
        drain();
        chk("op_error_sticky", 32'(op_error), exp_err);
        chk("op_legal_prod", 32'(last_pop_prod), 32'd12);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
